// File: rtl/l1_rd_port_dsc.sv
// Per-port L1 read front end: request FIFO, L1 pointer/offset calculation, discard detection.
// Optional statistics counters are enabled with the L1_RD_PORT_STATS_EN macro.
module l1_rd_port_dsc #(
    parameter int nstrms       = 64,
    parameter int nstrms_width = $clog2(nstrms),
    parameter int nports       = 8,
    parameter int portid       = 0,
    parameter int ptr_width    = 8,
    parameter int cl_size      = 8,
    parameter int clofs_width  = $clog2(cl_size),
    parameter int tag_width    = 4,
    parameter int fifo_depth   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [nstrms-1:0]              i_rst_end,
    input  logic [nstrms-1:0]              i_l1_end,
    input  logic [nstrms-1:0]              i_single_v,
    input  logic                           i_rd_v,
    output logic                           i_rd_r,
    input  logic [nstrms_width-1:0]        i_rd_sid,
    input  logic [tag_width-1:0]           i_rd_tag,
    input  logic [nports-1:0]              i_rd_acts,
    input  logic [nports*nstrms_width-1:0] i_rd_sids,
    output logic                           o_rd_act,
    input  logic [nstrms*ptr_width-1:0]    i_ptrs,
    output logic                           o_addr_v,
    input  logic                           o_addr_r,
    output logic [ptr_width-1:0]           o_addr_ptr,
    output logic [nstrms_width-1:0]        o_addr_sid,
    output logic [tag_width-1:0]           o_addr_tag,
    output logic                           o_addr_dsc,
    output logic [nstrms-1:0]              o_req_v,
    input  logic [nstrms-1:0]              o_req_r,
    output logic [31:0]                    o_cnt_rd,
    output logic [31:0]                    o_cnt_dsc
);

    localparam int fifo_aw    = $clog2(fifo_depth);
    localparam int hits_width = clofs_width + 1;

    logic [nstrms_width-1:0] sid_mem [fifo_depth];
    logic [tag_width-1:0]    tag_mem [fifo_depth];
    logic [fifo_aw:0]        wr_ptr;
    logic [fifo_aw:0]        rd_ptr;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;

    logic                    h_v;
    logic [nstrms_width-1:0] h_sid;
    logic [tag_width-1:0]    h_tag;

    logic [hits_width-1:0]   hits;
    logic [ptr_width-1:0]    ptr_cur;
    logic [ptr_width-1:0]    ptr;
    logic [hits_width-1:0]   lo_sum;
    logic                    carry;
    logic                    dsc;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[fifo_aw] != rd_ptr[fifo_aw]) &&
                    (wr_ptr[fifo_aw-1:0] == rd_ptr[fifo_aw-1:0]);
    // Ready is held low while reset is asserted, independent of FIFO state.
    assign i_rd_r = reset & ~full;
    assign push   = i_rd_v & i_rd_r;

    assign h_v    = ~empty;
    assign h_sid  = sid_mem[rd_ptr[fifo_aw-1:0]];
    assign h_tag  = tag_mem[rd_ptr[fifo_aw-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < fifo_depth; i++) begin
                sid_mem[i] <= '0;
                tag_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                sid_mem[wr_ptr[fifo_aw-1:0]] <= i_rd_sid;
                tag_mem[wr_ptr[fifo_aw-1:0]] <= i_rd_tag;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Same-stream reads consumed this cycle by lower-numbered ports shift our pointer.
    always_comb begin
        hits = '0;
        for (int i = 0; i < nports; i++) begin
            if (i < portid && i_rd_acts[i] &&
                i_rd_sids[i*nstrms_width +: nstrms_width] == h_sid) begin
                hits = hits + hits_width'(1);
            end
        end
    end

    assign ptr_cur = i_ptrs[h_sid*ptr_width +: ptr_width];
    assign ptr     = ptr_cur + ptr_width'(hits);
    assign lo_sum  = {1'b0, ptr_cur[clofs_width-1:0]} + hits;
    assign carry   = lo_sum[clofs_width];
    assign dsc     = i_l1_end[h_sid] | (i_rst_end[h_sid] & i_single_v[h_sid] & carry);

    always_comb begin
        o_addr_v = 1'b0;
        o_req_v  = '0;
        pop      = 1'b0;
        if (dsc) begin
            o_addr_v = h_v;
            pop      = h_v & o_addr_r;
        end else begin
            o_addr_v = h_v & o_req_r[h_sid];
            pop      = h_v & o_addr_r & o_req_r[h_sid];
            if (h_v && o_addr_r) begin
                o_req_v[h_sid] = 1'b1;
            end
        end
    end

    assign o_rd_act   = h_v & pop & ~dsc;
    assign o_addr_ptr = o_rd_act ? ptr : '0;
    assign o_addr_sid = h_sid;
    assign o_addr_tag = h_tag;
    assign o_addr_dsc = dsc;

`ifdef L1_RD_PORT_STATS_EN
    logic [31:0] cnt_rd;
    logic [31:0] cnt_dsc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_rd  <= '0;
            cnt_dsc <= '0;
        end else begin
            if (o_rd_act && cnt_rd != '1) begin
                cnt_rd <= cnt_rd + 32'd1;
            end
            if (pop && dsc && cnt_dsc != '1) begin
                cnt_dsc <= cnt_dsc + 32'd1;
            end
        end
    end

    assign o_cnt_rd  = cnt_rd;
    assign o_cnt_dsc = cnt_dsc;
`else
    assign o_cnt_rd  = '0;
    assign o_cnt_dsc = '0;
`endif

endmodule

// File: tb/tb_l1_rd_port_dsc.sv
// Scoreboard bench for l1_rd_port_dsc (instance at portid 2); expected responses are queued at push time.
module tb_l1_rd_port_dsc;

    localparam int nstrms = 64;
    localparam int sw     = 6;
    localparam int nports = 8;
    localparam int pw     = 8;
    localparam int tw     = 4;
`ifdef L1_RD_PORT_STATS_EN
    localparam bit stats = 1'b1;
`else
    localparam bit stats = 1'b0;
`endif

    typedef struct {
        logic [sw-1:0] sid;
        logic [tw-1:0] tag;
        logic          dsc;
        logic [pw-1:0] ptr;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [nstrms-1:0]       i_rst_end;
    logic [nstrms-1:0]       i_l1_end;
    logic [nstrms-1:0]       i_single_v;
    logic                    i_rd_v;
    logic                    i_rd_r;
    logic [sw-1:0]           i_rd_sid;
    logic [tw-1:0]           i_rd_tag;
    logic [nports-1:0]       i_rd_acts;
    logic [nports*sw-1:0]    i_rd_sids;
    logic                    o_rd_act;
    logic [nstrms*pw-1:0]    i_ptrs;
    logic                    o_addr_v;
    logic                    o_addr_r;
    logic [pw-1:0]           o_addr_ptr;
    logic [sw-1:0]           o_addr_sid;
    logic [tw-1:0]           o_addr_tag;
    logic                    o_addr_dsc;
    logic [nstrms-1:0]       o_req_v;
    logic [nstrms-1:0]       o_req_r;
    logic [31:0]             o_cnt_rd;
    logic [31:0]             o_cnt_dsc;

    int   vectors = 0;
    int   errors  = 0;
    exp_t sb[$];

    l1_rd_port_dsc #(.portid(2)) dut (
        .clk(clk), .reset(reset),
        .i_rst_end(i_rst_end), .i_l1_end(i_l1_end), .i_single_v(i_single_v),
        .i_rd_v(i_rd_v), .i_rd_r(i_rd_r), .i_rd_sid(i_rd_sid), .i_rd_tag(i_rd_tag),
        .i_rd_acts(i_rd_acts), .i_rd_sids(i_rd_sids), .o_rd_act(o_rd_act),
        .i_ptrs(i_ptrs), .o_addr_v(o_addr_v), .o_addr_r(o_addr_r),
        .o_addr_ptr(o_addr_ptr), .o_addr_sid(o_addr_sid), .o_addr_tag(o_addr_tag),
        .o_addr_dsc(o_addr_dsc), .o_req_v(o_req_v), .o_req_r(o_req_r),
        .o_cnt_rd(o_cnt_rd), .o_cnt_dsc(o_cnt_dsc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] expCnt(input int n);
        return stats ? 32'(n) : 32'd0;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) sync();
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic applyStimulus(input logic [sw-1:0] sid, input logic [tw-1:0] tag,
                                 input logic dsc, input logic [pw-1:0] ptr);
        exp_t e;
        int budget = 0;
        while (!i_rd_r && budget < 50) begin
            sync();
            budget++;
        end
        if (!i_rd_r) begin
            vectors++;
            errors++;
            $display("[TB] FAIL push_timeout: got i_rd_r=0, expected 1 within 50 cycles");
            return;
        end
        i_rd_sid = sid;
        i_rd_tag = tag;
        i_rd_v   = 1'b1;
        e.sid = sid; e.tag = tag; e.dsc = dsc; e.ptr = dsc ? '0 : ptr;
        sb.push_back(e);
        sync();
        i_rd_v = 1'b0;
    endtask

    // Monitor: every accepted L1 address is matched against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && o_addr_v && o_addr_r) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("[TB] FAIL unexpected_resp: got sid=%0d tag=%0d, expected none", o_addr_sid, o_addr_tag);
                end else begin
                    e = sb.pop_front();
                    checkOutput("resp_sid", 64'(o_addr_sid), 64'(e.sid));
                    checkOutput("resp_tag", 64'(o_addr_tag), 64'(e.tag));
                    checkOutput("resp_dsc", 64'(o_addr_dsc), 64'(e.dsc));
                    checkOutput("resp_ptr", 64'(o_addr_ptr), 64'(e.ptr));
                    checkOutput("resp_rd_act", 64'(o_rd_act), 64'(!e.dsc));
                    checkOutput("resp_req_v", 64'(o_req_v), e.dsc ? 64'd0 : (64'd1 << e.sid));
                end
            end
        end
    end

    initial begin
        int budget;
        reset      = 1'b0;
        i_rst_end  = '0;
        i_l1_end   = '0;
        i_single_v = '0;
        i_rd_v     = 1'b0;
        i_rd_sid   = '0;
        i_rd_tag   = '0;
        i_rd_acts  = '0;
        i_rd_sids  = '0;
        i_ptrs     = '0;
        o_addr_r   = 1'b1;
        o_req_r    = '1;

        waitCycles(3);
        @(negedge clk);
        checkOutput("rst_rd_r", 64'(i_rd_r), 64'd0);
        checkOutput("rst_addr_v", 64'(o_addr_v), 64'd0);
        checkOutput("rst_req_v", 64'(o_req_v), 64'd0);
        checkOutput("rst_rd_act", 64'(o_rd_act), 64'd0);
        checkOutput("rst_addr_ptr", 64'(o_addr_ptr), 64'd0);
        checkOutput("rst_cnt_rd", 64'(o_cnt_rd), 64'd0);
        checkOutput("rst_cnt_dsc", 64'(o_cnt_dsc), 64'd0);
        sync();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_rd_r", 64'(i_rd_r), 64'd1);
        sync();

        // Basic read, one-cycle push-to-head latency.
        i_ptrs[3*pw +: pw] = 8'h10;
        applyStimulus(6'd3, 4'd5, 1'b0, 8'h10);
        @(negedge clk);
        checkOutput("s1_latency_addr_v", 64'(o_addr_v), 64'd1);
        waitCycles(3);
        @(negedge clk);
        checkOutput("s1_cnt_rd", 64'(o_cnt_rd), 64'(expCnt(1)));
        checkOutput("s1_cnt_dsc", 64'(o_cnt_dsc), 64'd0);
        sync();

        // Lower-port offset, then carry-driven discard.
        i_rd_acts = 8'b0000_0011;
        i_rd_sids[0 +: sw]  = 6'd5;
        i_rd_sids[sw +: sw] = 6'd5;
        i_ptrs[5*pw +: pw]  = 8'h0E;
        applyStimulus(6'd5, 4'd6, 1'b0, 8'h10);
        waitCycles(3);
        i_rst_end[5]  = 1'b1;
        i_single_v[5] = 1'b1;
        i_ptrs[5*pw +: pw] = 8'h0D;
        applyStimulus(6'd5, 4'd7, 1'b0, 8'h0F);
        waitCycles(3);
        i_ptrs[5*pw +: pw] = 8'h0E;
        applyStimulus(6'd5, 4'd8, 1'b1, 8'h10);
        waitCycles(3);
        i_rd_acts  = '0;
        i_rst_end  = '0;
        i_single_v = '0;

        // Ended L1 stream: tagged reads come back in order as discards.
        i_l1_end[7] = 1'b1;
        applyStimulus(6'd7, 4'd1, 1'b1, 8'h00);
        applyStimulus(6'd7, 4'd2, 1'b1, 8'h00);
        applyStimulus(6'd7, 4'd3, 1'b1, 8'h00);
        waitCycles(4);
        i_l1_end[7] = 1'b0;
        @(negedge clk);
        checkOutput("s3_cnt_rd", 64'(o_cnt_rd), 64'(expCnt(3)));
        checkOutput("s3_cnt_dsc", 64'(o_cnt_dsc), 64'(expCnt(4)));
        sync();

        // Pointer update back-pressure fills the FIFO.
        o_req_r[4] = 1'b0;
        i_ptrs[4*pw +: pw] = 8'h20;
        applyStimulus(6'd4, 4'd8, 1'b0, 8'h20);
        applyStimulus(6'd4, 4'd9, 1'b0, 8'h20);
        @(negedge clk);
        checkOutput("s4_full_rd_r", 64'(i_rd_r), 64'd0);
        checkOutput("s4_stall_addr_v", 64'(o_addr_v), 64'd0);
        waitCycles(5);
        @(negedge clk);
        checkOutput("s4_still_stalled", 64'(o_addr_v), 64'd0);
        sync();
        o_req_r[4] = 1'b1;
        @(negedge clk);
        checkOutput("s4_release_addr_v", 64'(o_addr_v), 64'd1);
        waitCycles(4);
        @(negedge clk);
        checkOutput("s4_cnt_rd", 64'(o_cnt_rd), 64'(expCnt(5)));
        checkOutput("s4_rd_r", 64'(i_rd_r), 64'd1);
        sync();

        // Asynchronous reset while stalled with a full FIFO.
        o_req_r[4] = 1'b0;
        applyStimulus(6'd4, 4'd10, 1'b0, 8'h20);
        applyStimulus(6'd4, 4'd11, 1'b0, 8'h20);
        waitCycles(2);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        checkOutput("s5_rst_addr_v", 64'(o_addr_v), 64'd0);
        checkOutput("s5_rst_rd_r", 64'(i_rd_r), 64'd0);
        checkOutput("s5_rst_req_v", 64'(o_req_v), 64'd0);
        checkOutput("s5_rst_cnt_rd", 64'(o_cnt_rd), 64'd0);
        waitCycles(2);
        reset   = 1'b1;
        o_req_r = '1;
        @(negedge clk);
        checkOutput("s5_post_addr_v", 64'(o_addr_v), 64'd0);
        checkOutput("s5_post_rd_r", 64'(i_rd_r), 64'd1);
        waitCycles(3);
        @(negedge clk);
        checkOutput("s5_no_stale", 64'(o_addr_v), 64'd0);
        sync();
        applyStimulus(6'd3, 4'd12, 1'b0, 8'h10);
        waitCycles(3);
        @(negedge clk);
        checkOutput("s5_cnt_rd", 64'(o_cnt_rd), 64'(expCnt(1)));
        checkOutput("s5_cnt_dsc", 64'(o_cnt_dsc), 64'd0);

        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            sync();
            budget++;
        end
        if (sb.size() != 0) begin
            vectors++;
            errors++;
            $display("[TB] FAIL drain: got %0d responses outstanding, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/l1_rd_port_dsc.md
Name: l1_rd_port_dsc

Overview:
- Per-port L1 read front end; one instance per AFU read port, nports instances side by side under l1_ctrl_top.
- Buffers AFU read requests with tags in a small FIFO and computes the L1 BRAM pointer, offset by same-stream reads on lower-numbered ports in the same cycle.
- Issues the per-stream global pointer update request.
- Out-of-bounds and ended-stream reads are no longer silently dropped: they are returned in order with a discard flag, so the AFU always gets one response per accepted read.

Parameters:
- nstrms, 64, number of streams
- nstrms_width, $clog2(nstrms), stream id width
- nports, 8, number of read ports
- portid, 0, index of this port (0..nports-1)
- ptr_width, 8, L1 read pointer width
- cl_size, 8, reads per cacheline (>= nports, power of 2)
- clofs_width, $clog2(cl_size), cacheline offset width
- tag_width, 4, AFU read tag width
- fifo_depth, 2, input request FIFO depth (power of 2, >= 2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- i_rst_end  in  nstrms  L2 stream ended, per stream
- i_l1_end  in  nstrms  L1 stream ended, per stream
- i_single_v  in  nstrms  only one valid L1 line, per stream
- i_rd_v  in  1  AFU read valid
- i_rd_r  out  1  AFU read ready
- i_rd_sid  in  nstrms_width  requested stream
- i_rd_tag  in  tag_width  AFU read tag
- i_rd_acts  in  nports  o_rd_act of all ports
- i_rd_sids  in  nports*nstrms_width  o_addr_sid of all ports
- o_rd_act  out  1  this port consumes a request this cycle
- i_ptrs  in  nstrms*ptr_width  current pointer per stream
- o_addr_v  out  1  L1 address valid
- o_addr_r  in  1  L1 address ready
- o_addr_ptr  out  ptr_width  L1 read pointer
- o_addr_sid  out  nstrms_width  stream of head request
- o_addr_tag  out  tag_width  tag of head request
- o_addr_dsc  out  1  head request discarded (no BRAM read)
- o_req_v  out  nstrms  one-hot pointer update request
- o_req_r  in  nstrms  pointer update ready
- o_cnt_rd  out  32  accepted non-discarded reads
- o_cnt_dsc  out  32  discarded reads

Behaviour:
- Reset (reset=0, async): FIFO empty. o_addr_v=0, o_req_v=0, o_rd_act=0, o_addr_ptr=0, counters=0. i_rd_r=0 while reset is asserted and 1 on the first cycle after release. Requests in flight are flushed.
- FIFO:
  - i_rd_r = ~full.
  - Push on i_rd_v & i_rd_r.
  - Simultaneous push and pop when full is not allowed, because i_rd_r depends only on full (no ready pass-through).
  - Push-to-head latency is 1 cycle.
  - Head fields: h_v, h_sid, h_tag.
- Hit count: hits = number of i < portid with i_rd_acts[i] & i_rd_sids[i]==h_sid. For portid=0, hits=0.
- Pointer: ptr = i_ptrs[h_sid] + hits, modulo 2^ptr_width.
- carry = bit clofs_width of (ptr_cur[clofs_width-1:0] + hits).
- dsc = i_l1_end[h_sid] | (i_rst_end[h_sid] & i_single_v[h_sid] & carry).
- Discarded head:
  - o_addr_v = h_v, o_addr_dsc = 1, o_req_v = 0.
  - Pop on o_addr_r.
  - o_cnt_dsc += 1.
- Normal head (fork semantics):
  - o_addr_v = h_v & o_req_r[h_sid].
  - o_req_v = onehot(h_sid) & {nstrms{h_v & o_addr_r}}.
  - Pop when h_v & o_addr_r & o_req_r[h_sid]. o_cnt_rd += 1.
- o_rd_act = h_v & pop & ~dsc. Discarded requests never perturb lower-port offsets of higher ports.
- o_addr_ptr = ptr when o_rd_act, else 0. o_addr_sid = h_sid and o_addr_tag = h_tag at all times.
- Responses stay strictly in order; the tag is informational.
- Counters saturate at 2^32-1.

Optional Feature:
- Macro: L1_RD_PORT_STATS_EN.
- Defined: o_cnt_rd and o_cnt_dsc are live as above.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.

Test Plan:
- portid=0, sid=3, i_ptrs[3]=0x10, ready all 1 → o_addr_v one cycle after push, o_addr_ptr=0x10, o_req_v=1<<3, o_addr_dsc=0, o_cnt_rd=1.
- portid=2, ports 0,1 active on sid 5, ptr=0x0E → o_addr_ptr=0x10, carry=1. With i_rst_end[5]=i_single_v[5]=1: o_addr_dsc=1, o_req_v=0, o_rd_act=0.
- i_l1_end[7]=1, three tagged reads (tags 1,2,3) on sid 7 → three responses in order, tags 1,2,3, all o_addr_dsc=1, o_cnt_dsc=3, o_req_v never asserted.
- o_req_r[4]=0 for 5 cycles, sid 4 head → o_addr_v=0, FIFO fills, i_rd_r=0 after 2 pushes. Release → pops one per cycle, no loss.
- Reset asserted mid-stall with full FIFO → outputs zero immediately (async), i_rd_r=0 during reset, FIFO empty afterwards, no stale response.
- Macro undefined → o_cnt_rd=o_cnt_dsc=0 throughout the first scenario.
